// File: rtl/bin2bcd_16_seq.sv
// bin2bcd_16_seq: sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake
module bin2bcd_16_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_bin,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_busy,
    output logic                o_done
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          r_state, w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]   r_scratch, r_bcd, w_adj, w_shifted;
    logic [CW-1:0]   r_cnt;
    logic            r_done, w_load, w_last;

    // state register
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state plus load/last-shift strobes
    always_comb begin
        w_load = 1'b0;
        w_last = 1'b0;
        w_next = r_state;
        w_load = (r_state == IDLE) && i_start;
        w_last = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
        w_next = w_load ? SHIFT : w_last ? IDLE : r_state;
    end

    // add 3 to every scratch digit >= 5 before the shift
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++)
            w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ? r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
    end

    // shreg MSB enters units bit 0; adjusted digits never carry out of the top
    assign w_shifted = (w_adj << 1) | BW'(r_shreg[WIDTH-1]);

    // datapath: capture on start, one shift per clock, publish result on the last shift
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_shreg   <= i_bin;
                r_scratch <= '0;
                r_cnt     <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                r_scratch <= w_shifted;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) r_bcd <= w_shifted;
            end
        end
    end

    assign o_bcd  = r_bcd;
    assign o_busy = (r_state == SHIFT);
    assign o_done = r_done;
endmodule

// File: tb/tb_bin2bcd_16_seq.sv
// tb_bin2bcd_16_seq: cycle model plus decimal-reference scoreboard for bin2bcd_16_seq
module tb_bin2bcd_16_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic [19:0] bcd;
    logic        busy, done;

    int n_checks = 0;
    int n_err    = 0;

    logic [19:0] q[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [19:0] m_bcd  = '0;
    int          m_cnt  = 0;

    bin2bcd_16_seq dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_start(start),
        .i_bin(bin),
        .o_bcd(bcd),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // reference cycle model: accepts start only when idle, done 16 edges after acceptance
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_bcd  = '0;
            q.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    q.push_back(to_bcd(int'(bin)));
                end
            end else begin
                m_cnt++;
                if (m_cnt == 16) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (q.size() > 0) m_bcd = q.pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("bcd", 32'(bcd), 32'(m_bcd));
        if (busy && done) check("busy_and_done", 32'(1), 32'(0));
    end

    task automatic conv(input logic [15:0] v);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        conv(16'd0);
        conv(16'd65535);
        // reset held 3 cycles in the middle of a conversion
        @(negedge clk);
        bin = 16'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // start pulses during busy are ignored
        @(negedge clk);
        bin = 16'd12345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin = 16'd999;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        // start held high: back-to-back conversions every 17 cycles
        bin = 16'd9999;
        start = 1'b1;
        repeat (17) @(negedge clk);
        bin = 16'd10000;
        repeat (34) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        // reset at shift cycle 8 aborts with no done, then a fresh conversion
        bin = 16'd40000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        conv(16'd7);
        for (int i = 0; i < 1000; i++) conv(16'($urandom_range(0, 65535)));
        conv(16'd9);
        conv(16'd10);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
